// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / single shift / parallel load / counted burst shift.
// Optional rotate fill enabled by defining UNIV_SHIFT_ROTATE_EN (adds input rot).
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             left,
  input  logic             in,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] n,
`ifdef UNIV_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic             sh_dir, sh_fill;
  logic [WIDTH-1:0] sh_val;

  // Shift datapath is shared: burst uses the latched direction, idle uses the live one.
  always_comb begin
    sh_dir = (state_q == BURST) ? dir_q : left;
`ifdef UNIV_SHIFT_ROTATE_EN
    sh_fill = rot ? (sh_dir ? q_q[WIDTH-1] : q_q[0]) : in;
`else
    sh_fill = in;
`endif
    sh_val = sh_dir ? {q_q[WIDTH-2:0], sh_fill} : {sh_fill, q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        case (mode)
          2'b01: q_d = sh_val;
          2'b10: q_d = d;
          2'b11: begin
            if (n == '0) begin
              done_d = 1'b1;
            end else begin
              cnt_d   = n;
              dir_d   = left;
              state_d = BURST;
            end
          end
          default: ;
        endcase
      end
      BURST: begin
        q_d   = sh_val;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign so   = left ? q_q[WIDTH-1] : q_q[0];
  assign busy = (state_q == BURST);
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomized bench for univ_shift_reg against an arithmetic model of remaining burst shifts.
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, left, in, rot;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] q;
  logic             so, busy, done;

  int n_chk = 0;
  int n_bad = 0;

  // model state
  int m_q, m_rem, m_dir;
  bit m_done;
  int done_cnt;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .left(left), .in(in), .d(d), .n(n),
`ifdef UNIV_SHIFT_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .so(so), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int shift1(input int v, input int dir, input int fill_in, input bit r);
    int f;
    if (r) f = dir ? (v >> (WIDTH-1)) & 1 : v & 1;
    else   f = fill_in;
    if (dir) return ((v * 2) + f) % (1 << WIDTH);
    else     return (v / 2) + f * (1 << (WIDTH-1));
  endfunction

  // Drive one cycle, advance the model with the same inputs, then check outputs.
  task automatic cyc(input bit r, input int md, input bit l, input bit i,
                     input int dd, input int nn, input bit ro);
    bit rot_eff;
    @(negedge clk);
    rst = r; mode = md[1:0]; left = l; in = i; d = dd[WIDTH-1:0]; n = nn[CNT_W-1:0]; rot = ro;
`ifdef UNIV_SHIFT_ROTATE_EN
    rot_eff = ro;
`else
    rot_eff = 1'b0;
`endif
    @(posedge clk);
    if (r) begin
      m_q = 0; m_rem = 0; m_done = 0;
    end else if (m_rem > 0) begin
      m_q = shift1(m_q, m_dir, i, rot_eff);
      m_rem--;
      m_done = (m_rem == 0);
    end else begin
      m_done = 0;
      case (md)
        1: m_q = shift1(m_q, l, i, rot_eff);
        2: m_q = dd % (1 << WIDTH);
        3: if (nn == 0) m_done = 1; else begin m_dir = l; m_rem = nn; end
        default: ;
      endcase
    end
    #1;
    chk("q", int'(q), m_q);
    chk("busy", int'(busy), int'(m_rem > 0));
    chk("done", int'(done), int'(m_done));
    chk("so", int'(so), l ? (m_q >> (WIDTH-1)) & 1 : m_q & 1);
    if (done) done_cnt++;
  endtask

  initial begin
    rst = 1; mode = 0; left = 0; in = 0; d = 0; n = 0; rot = 0;
    m_q = 0; m_rem = 0; m_dir = 0; m_done = 0; done_cnt = 0;

    cyc(1, 2, 0, 0, 8'hFF, 0, 0);               // reset overrides a load
    chk("rst_q", int'(q), 0);

    // load A5, shift left fill 1 -> 4B, so=0
    cyc(0, 2, 0, 0, 8'hA5, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0);
    chk("lsh_q", int'(q), 8'h4B);
    chk("lsh_so", int'(so), 0);

    // from A5 shift right fill 0 -> 52
    cyc(0, 2, 0, 0, 8'hA5, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rsh_q", int'(q), 8'h52);

    // burst n=3 left from 81, loads ignored during burst
    cyc(0, 2, 0, 0, 8'h81, 0, 0);
    done_cnt = 0;
    cyc(0, 3, 1, 0, 0, 3, 0);
    chk("b_busy0", int'(busy), 1);
    for (int k = 0; k < 3; k++) cyc(0, 2, 0, 1'b0, 8'hFF, 9, 0);
    chk("b_q", int'(q), 8'h08);
    chk("b_busy", int'(busy), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("b_done_cnt", done_cnt, 1);

    // n=0: done pulse only
    done_cnt = 0;
    cyc(0, 3, 1, 1, 0, 0, 0);
    chk("n0_q", int'(q), 8'h08);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("n0_done_cnt", done_cnt, 1);

    // burst n=5 aborted by reset after 2nd shift
    done_cnt = 0;
    cyc(0, 3, 1, 1, 0, 5, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("abort_done_cnt", done_cnt, 0);

`ifdef UNIV_SHIFT_ROTATE_EN
    cyc(0, 2, 0, 0, 8'h81, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 1);
    chk("rotl_q", int'(q), 8'h03);
    cyc(0, 2, 0, 0, 8'h81, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("rotr_q", int'(q), 8'hC0);
`endif

    // random traffic, burst commands common, rare resets
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 15),
          $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
